// File: rtl/mem_responder_pkg.sv
// Shared defaults and widths for the memory responder and its latency pipe.
package mem_responder_pkg;

  localparam int DEF_LATENCY = 4;
  localparam int DEF_ADDR_W  = 16;
  localparam int DATA_W      = 16;
  localparam int OUTST_W     = 3;

  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/mem_resp_pipe.sv
// Fixed-latency shift pipeline carrying {valid, data}; invalid slots carry zero data
// so the output never shows stale or unknown words.
module mem_resp_pipe
  import mem_responder_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY,
  parameter int WIDTH   = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [LATENCY-1:0]            r_valid;
  logic [LATENCY-1:0][WIDTH-1:0] r_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      r_data  <= '0;
    end else begin
      r_valid[0] <= in_valid;
      r_data[0]  <= in_valid ? in_data : '0;
      for (int i = 1; i < LATENCY; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_data[i]  <= r_data[i-1];
      end
    end
  end

  assign out_valid = r_valid[LATENCY-1];
  assign out_data  = r_data[LATENCY-1];

endmodule

// File: rtl/mem_responder.sv
// Always-ready single-port word memory answering reads a fixed LATENCY cycles after
// issue, fully pipelined, with an in-flight read counter.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_en,
  input  logic               mem_write,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [DATA_W-1:0]  data_in,
  output logic [DATA_W-1:0]  data_out,
  output logic               data_valid,
  output logic               busy,
  output logic [OUTST_W-1:0] outstanding
);

  localparam int DEPTH = 2 ** (ADDR_W - 1);

  word_t              r_mem [DEPTH];
  logic [OUTST_W-1:0] r_outstanding;
  logic [ADDR_W-2:0]  w_word;
  logic               w_rd_en;
  logic               w_wr_en;
  word_t              w_rd_data;
  logic               w_unused;

  assign w_word   = addr[ADDR_W-1:1];
  assign w_unused = addr[0];
  assign w_rd_en  = mem_en & ~mem_write;
  // Writes are gated by reset because the array itself is never cleared.
  assign w_wr_en  = mem_en & mem_write & rst;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_word] <= data_in;
    end
  end

  // Stage 0 of the pipe is the registered read port of the array.
  assign w_rd_data = r_mem[w_word];

  mem_resp_pipe #(
    .LATENCY(LATENCY),
    .WIDTH  (DATA_W)
  ) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (w_rd_en),
    .in_data  (w_rd_data),
    .out_valid(data_valid),
    .out_data (data_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_outstanding <= '0;
    end else begin
      case ({w_rd_en, data_valid})
        2'b10:   r_outstanding <= r_outstanding + 3'd1;
        2'b01:   r_outstanding <= r_outstanding - 3'd1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  assign outstanding = r_outstanding;
  assign busy        = (r_outstanding != '0);

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning cycles from read acceptance to data_valid (legal 1..7).
REQ-002 SHALL have parameter ADDR_W, default 16, meaning byte-address width; word index = addr[ADDR_W-1:1].
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 mem_en  input  1  request strobe from the cache-side interface; one request per asserted cycle.
REQ-006 mem_write  input  1  qualifies mem_en: 1 = write, 0 = read.
REQ-007 addr  input  ADDR_W  byte address of request (bit 0 ignored).
REQ-008 data_in  input  16  write data.
REQ-009 data_out  output  16  read data, meaningful only when data_valid=1.
REQ-010 data_valid  output  1  one-cycle pulse per completed read.
REQ-011 busy  output  1  high while any read is in flight.
REQ-012 outstanding  output  3  count of reads in flight.

Function
REQ-013 Storage SHALL be 2^(ADDR_W-1) 16-bit words, single port, synchronous write.
REQ-014 Write (mem_en=1, mem_write=1) SHALL update the addressed word at that rising edge; no response pulse, not counted as outstanding.
REQ-015 Read (mem_en=1, mem_write=0) SHALL sample the array at acceptance (read-at-issue) and present that value on data_out with data_valid=1 exactly LATENCY cycles later.
REQ-016 Reads SHALL be fully pipelined: a new read accepted every cycle; responses return in issue order, one per cycle, no bubbles inserted.
REQ-017 Read of the word written on the immediately preceding edge SHALL return the new value; read and write in the same cycle cannot occur (single port).
REQ-018 Pipeline SHALL be a LATENCY-deep shift of {valid, data}; stage 0 loads on read acceptance, last stage drives data_valid/data_out.
REQ-019 outstanding SHALL increment on read acceptance, decrement on data_valid, unchanged when both occur in one cycle; never exceeds LATENCY.
REQ-020 busy SHALL equal (outstanding != 0).
REQ-021 mem_en=0 SHALL insert an invalid slot; addr/data_in/mem_write ignored.
REQ-022 data_out SHALL hold 16'h0000 when data_valid=0 (no X propagation to the cache).
REQ-023 No request rejection: the responder is always ready; mem_en is never back-pressured.

Reset
REQ-024 rst low SHALL asynchronously clear all pipeline valid bits, outstanding=0, busy=0, data_valid=0, data_out=16'h0000.
REQ-025 Reads in flight when rst asserts SHALL be discarded with no later data_valid pulse.
REQ-026 Array contents SHALL NOT be reset and SHALL be retained across rst.
REQ-027 Requests with mem_en=1 during rst low SHALL be ignored, including writes.

Structure
REQ-028 Shared package SHALL hold default LATENCY (4), default ADDR_W (16), data width 16, and outstanding-counter width 3.
REQ-029 The latency shift pipeline SHALL be a sub-module mem_resp_pipe (parameters LATENCY, width 16; ports clk, rst, in_valid, in_data, out_valid, out_data).
REQ-030 Storage array, counter and request decode SHALL reside in mem_responder.

Verification
REQ-031 Write 16'hBEEF to addr 16'h0010, next cycle read 16'h0010 -> data_valid exactly 4 cycles after read, data_out=16'hBEEF, outstanding 1 then 0.
REQ-032 Back-to-back reads of 16'h0000, 16'h0002, 16'h0004, 16'h0006 preloaded 16'h1111..16'h4444 -> four consecutive data_valid cycles 4..7 after first read, in order; outstanding peaks at 4.
REQ-033 Read 16'h0020 (holds 16'hAAAA), then write 16'h5555 to 16'h0020 next cycle -> returned data is 16'hAAAA.
REQ-034 Addresses 16'h0031 and 16'h0030 alias -> write via 16'h0031, read via 16'h0030 returns same value.
REQ-035 Issue 3 reads, assert rst low 2 cycles later, release -> no data_valid pulse, outstanding=0, busy=0; previously written data still readable.
REQ-036 Alternating read/idle pattern with LATENCY=1 -> data_valid on each cycle following a read, outstanding never exceeds 1.
